// File: rtl/nes_bus_master.sv
// Cartridge CPU-bus initiator: free-running M2 cycles carrying controller reads/writes to a mapper.
// Optional PPU A12 pulse engine is enabled by defining NES_BUS_MASTER_A12_PULSE_EN.
module nes_bus_master #(
   parameter int          M2_LO     = 8,
   parameter int          M2_HI     = 8,
   parameter logic [15:0] PARK_ADDR = 16'h0000,
   parameter int          A12_HI    = 4,
   parameter int          A12_GAP   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        req_we,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_wdat,
   output logic        ack,
   output logic [7:0]  rdat,
   output logic        busy,
   output logic        m2,
   output logic [15:0] addr,
   output logic        rw,
   output logic [7:0]  dout,
   output logic        dout_oe,
   input  logic [7:0]  din,
   input  logic        a12_req,
   input  logic [7:0]  a12_cnt,
   output logic        a12,
   output logic        a12_busy
);

   typedef enum logic {LO, HI} state_t;

   localparam logic [7:0] LO_LAST = 8'(M2_LO - 1);
   localparam logic [7:0] HI_LAST = 8'(M2_HI - 1);

   state_t     state;
   logic [7:0] cnt;

   // Requests are sampled at the end of the first LO clk, so a requester may swap fields during the ack clk
   // and still land on the very next bus cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= LO;
         cnt     <= 8'd0;
         m2      <= 1'b0;
         addr    <= PARK_ADDR;
         rw      <= 1'b1;
         dout    <= 8'h00;
         dout_oe <= 1'b0;
         ack     <= 1'b0;
         busy    <= 1'b0;
         rdat    <= 8'h00;
      end else begin
         ack <= 1'b0;
         case (state)
            LO: begin
               if (cnt == 8'd0) begin
                  if (req && !busy) begin
                     addr <= req_addr;
                     rw   <= !req_we;
                     dout <= req_wdat;
                     busy <= 1'b1;
                  end else begin
                     addr <= PARK_ADDR;
                     rw   <= 1'b1;
                  end
               end
               if (cnt == LO_LAST) begin
                  state   <= HI;
                  cnt     <= 8'd0;
                  m2      <= 1'b1;
                  dout_oe <= busy && !rw;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            HI: begin
               if (cnt == HI_LAST) begin
                  state   <= LO;
                  cnt     <= 8'd0;
                  m2      <= 1'b0;
                  dout_oe <= 1'b0;
                  if (busy) begin
                     ack  <= 1'b1;
                     busy <= 1'b0;
                     if (rw) rdat <= din;
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: state <= LO;
         endcase
      end
   end

`ifdef NES_BUS_MASTER_A12_PULSE_EN
   localparam logic [7:0] GAP_LAST = 8'(A12_GAP - 1);
   localparam logic [7:0] PLS_LAST = 8'(A12_HI - 1);

   logic       fall_tick;
   logic       pulse_ph;
   logic [7:0] rem;
   logic [7:0] gap_cnt;
   logic [7:0] pls_cnt;

   assign fall_tick = (state == HI) && (cnt == HI_LAST);

   // Burst = gap, pulse, gap, pulse, ..., pulse, gap; rem counts pulses still to be launched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a12      <= 1'b0;
         a12_busy <= 1'b0;
         pulse_ph <= 1'b0;
         rem      <= 8'd0;
         gap_cnt  <= 8'd0;
         pls_cnt  <= 8'd0;
      end else if (!a12_busy) begin
         if (a12_req && a12_cnt != 8'd0) begin
            a12_busy <= 1'b1;
            rem      <= a12_cnt;
            gap_cnt  <= 8'd0;
            pulse_ph <= 1'b0;
         end
      end else if (pulse_ph) begin
         if (pls_cnt == PLS_LAST) begin
            a12      <= 1'b0;
            pulse_ph <= 1'b0;
            gap_cnt  <= 8'd0;
         end else begin
            pls_cnt <= pls_cnt + 8'd1;
         end
      end else if (fall_tick) begin
         if (gap_cnt == GAP_LAST) begin
            if (rem == 8'd0) begin
               a12_busy <= 1'b0;
            end else begin
               a12      <= 1'b1;
               pulse_ph <= 1'b1;
               pls_cnt  <= 8'd0;
               rem      <= rem - 8'd1;
            end
         end else begin
            gap_cnt <= gap_cnt + 8'd1;
         end
      end
   end
`else
   logic unused_a12;
   assign unused_a12 = ^{a12_req, a12_cnt, A12_HI[0], A12_GAP[0]};
   assign a12        = 1'b0;
   assign a12_busy   = 1'b0;
`endif

endmodule

// File: tb/tb_nes_bus_master.sv
// Directed bench for nes_bus_master: reset, idle M2, writes, reads, late request, reset abort,
// back-to-back transactions and the A12 pulse engine (when NES_BUS_MASTER_A12_PULSE_EN is defined).
module tb_nes_bus_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0;
   logic        req_we = 1'b0;
   logic [15:0] req_addr = 16'h0000;
   logic [7:0]  req_wdat = 8'h00;
   logic        ack;
   logic [7:0]  rdat;
   logic        busy;
   logic        m2;
   logic [15:0] addr;
   logic        rw;
   logic [7:0]  dout;
   logic        dout_oe;
   logic [7:0]  din = 8'h00;
   logic        a12_req = 1'b0;
   logic [7:0]  a12_cnt = 8'h00;
   logic        a12;
   logic        a12_busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   nes_bus_master dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
      .req_wdat(req_wdat), .ack(ack), .rdat(rdat), .busy(busy), .m2(m2), .addr(addr),
      .rw(rw), .dout(dout), .dout_oe(dout_oe), .din(din), .a12_req(a12_req),
      .a12_cnt(a12_cnt), .a12(a12), .a12_busy(a12_busy)
   );

   // Returns 1 ns after the clk edge on which m2 falls (i.e. inside the first LO clk).
   task automatic sync_lo;
      logic prev;
      bit   found;
      found = 0;
      prev  = m2;
      for (int i = 0; i < 40 && !found; i++) begin
         @(posedge clk); #1;
         if (prev === 1'b1 && m2 === 1'b0) found = 1;
         prev = m2;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL sync_lo m2 fall seen=%0d required=1 within 40 clks", found);
      end
   endtask

   task automatic sync_hi;
      logic prev;
      bit   found;
      found = 0;
      prev  = m2;
      for (int i = 0; i < 40 && !found; i++) begin
         @(posedge clk); #1;
         if (prev === 1'b0 && m2 === 1'b1) found = 1;
         prev = m2;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL sync_hi m2 rise seen=%0d required=1 within 40 clks", found);
      end
   endtask

   // Caller is inside the first LO clk with req and fields driven; walks the 16 clks of the bus cycle.
   task automatic do_txn(input logic we, input logic [15:0] a, input logic [7:0] wd,
                         input logic [7:0] exp_rdat, input logic drop);
      logic [20:0] got, want;
      logic        hi;
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk); @(negedge clk);
         hi   = (k >= 8) && (k <= 15);
         got  = {m2, dout_oe, ack, busy, rw, addr};
         want = {hi, hi && we, (k == 16), (k < 16), !we, a};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL txn_k%0d {m2,oe,ack,busy,rw,addr} got %h required %h", k, got, want);
         end
         if (we) begin
            checks++;
            if (dout !== wd) begin
               errors++;
               $display("FAIL txn_dout_k%0d got %h required %h", k, dout, wd);
            end
         end
      end
      checks++;
      if (rdat !== exp_rdat) begin
         errors++;
         $display("FAIL txn_rdat addr %h got %h required %h", a, rdat, exp_rdat);
      end
      if (drop) req = 1'b0;
   endtask

   task automatic test_reset;
      logic [38:0] got;
      rst_n = 1'b0;
      #12;
      got = {m2, addr, rw, dout, dout_oe, ack, busy, rdat, a12, a12_busy};
      checks++;
      if (got !== {1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state got %h required %h", got,
                  {1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
      end
   endtask

   task automatic test_idle;
      logic exp_m2;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 48; k++) begin
         @(posedge clk); @(negedge clk);
         exp_m2 = ((k / 8) % 2) == 1;
         checks++;
         if (m2 !== exp_m2) begin
            errors++;
            $display("FAIL idle_m2_k%0d got %b required %b", k, m2, exp_m2);
         end
         checks++;
         if ({addr, rw, dout_oe, ack, busy} !== {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL idle_bus_k%0d got %h required %h", k,
                     {addr, rw, dout_oe, ack, busy}, {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
         end
      end
   endtask

   task automatic test_write;
      sync_lo;
      req = 1'b1; req_we = 1'b1; req_addr = 16'h8000; req_wdat = 8'h06;
      do_txn(1'b1, 16'h8000, 8'h06, 8'h00, 1'b1);
      @(posedge clk); @(negedge clk);
      checks++;
      if ({addr, rw, busy, ack} !== {16'h0000, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL write_park got %h required %h", {addr, rw, busy, ack},
                  {16'h0000, 1'b1, 1'b0, 1'b0});
      end
      sync_lo;
      req = 1'b1; req_we = 1'b1; req_addr = 16'h8001; req_wdat = 8'h3C;
      do_txn(1'b1, 16'h8001, 8'h3C, 8'h00, 1'b1);
   endtask

   task automatic test_mid_req;
      sync_hi;
      @(posedge clk); #1;
      din = 8'hA5; req = 1'b1; req_we = 1'b0; req_addr = 16'h6000;
      sync_lo;
      checks++;
      if ({ack, busy, addr, rw} !== {1'b0, 1'b0, 16'h0000, 1'b1}) begin
         errors++;
         $display("FAIL mid_req_dummy got %h required %h", {ack, busy, addr, rw},
                  {1'b0, 1'b0, 16'h0000, 1'b1});
      end
      do_txn(1'b0, 16'h6000, 8'h00, 8'hA5, 1'b1);
   endtask

   task automatic test_reset_mid;
      logic [36:0] got;
      sync_lo;
      req = 1'b1; req_we = 1'b1; req_addr = 16'h8000; req_wdat = 8'h77;
      repeat (10) @(posedge clk);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      req = 1'b0;
      got = {m2, addr, rw, dout, dout_oe, ack, busy, rdat};
      checks++;
      if (got !== {1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL reset_mid_state got %h required %h", got,
                  {1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); @(negedge clk);
         checks++;
         if ({ack, busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_noack_k%0d {ack,busy} got %b required 00", k, {ack, busy});
         end
      end
   endtask

   task automatic test_read;
      din = 8'h5A;
      sync_lo;
      req = 1'b1; req_we = 1'b0; req_addr = 16'hE123;
      do_txn(1'b0, 16'hE123, 8'h00, 8'h5A, 1'b1);
      din = 8'hFF;
      sync_lo;
      checks++;
      if (rdat !== 8'h5A) begin
         errors++;
         $display("FAIL read_hold_idle got %h required 5a", rdat);
      end
   endtask

   task automatic test_back_to_back;
      din = 8'h3C;
      sync_lo;
      req = 1'b1; req_we = 1'b0; req_addr = 16'hC000;
      do_txn(1'b0, 16'hC000, 8'h00, 8'h3C, 1'b0);
      din = 8'h00;
      req_we = 1'b1; req_addr = 16'hA001; req_wdat = 8'h99;
      do_txn(1'b1, 16'hA001, 8'h99, 8'h3C, 1'b1);
   endtask

   task automatic test_a12;
`ifdef NES_BUS_MASTER_A12_PULSE_EN
      int   falls, rises, hi_len;
      logic prev_m2, prev_a12;
      @(negedge clk);
      a12_cnt = 8'd3; a12_req = 1'b1;
      @(negedge clk);
      a12_req = 1'b0;
      checks++;
      if (a12_busy !== 1'b1) begin
         errors++;
         $display("FAIL a12_start busy got %b required 1", a12_busy);
      end
      falls = 0; rises = 0; hi_len = 0;
      prev_m2 = m2; prev_a12 = a12;
      for (int k = 0; k < 400 && a12_busy; k++) begin
         @(negedge clk);
         if (prev_m2 && !m2) falls++;
         if (a12 && !prev_a12) begin
            rises++;
            hi_len = 0;
            checks++;
            if (falls < 4) begin
               errors++;
               $display("FAIL a12_gap_rise%0d falls got %0d required >=4", rises, falls);
            end
         end
         if (a12) hi_len++;
         if (!a12 && prev_a12) begin
            falls = 0;
            checks++;
            if (hi_len != 4) begin
               errors++;
               $display("FAIL a12_width_pulse%0d got %0d required 4", rises, hi_len);
            end
         end
         prev_m2 = m2; prev_a12 = a12;
      end
      checks++;
      if (rises != 3) begin
         errors++;
         $display("FAIL a12_pulse_count got %0d required 3", rises);
      end
      checks++;
      if (a12_busy !== 1'b0) begin
         errors++;
         $display("FAIL a12_done busy got %b required 0", a12_busy);
      end
      a12_cnt = 8'd0; a12_req = 1'b1;
      @(negedge clk);
      a12_req = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         checks++;
         if ({a12, a12_busy} !== 2'b00) begin
            errors++;
            $display("FAIL a12_zero_k%0d got %b required 00", k, {a12, a12_busy});
         end
      end
`else
      @(negedge clk);
      a12_cnt = 8'd3; a12_req = 1'b1;
      @(negedge clk);
      a12_req = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         checks++;
         if ({a12, a12_busy} !== 2'b00) begin
            errors++;
            $display("FAIL a12_tied_k%0d got %b required 00", k, {a12, a12_busy});
         end
      end
`endif
   endtask

   initial begin
      test_reset;
      test_idle;
      test_write;
      test_mid_req;
      test_reset_mid;
      test_read;
      test_back_to_back;
      test_a12;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
